// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response channel bundle for the ALU sequencer.
//               Request channel : req_valid/req_ready, req_op, req_a, req_b,
//                                 req_amt.
//               Response channel: rsp_valid/rsp_ready, rsp_data, rsp_n/z/p.
//               master = requester/consumer side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [AMT_W-1:0] req_amt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_p;

  modport master (
    output req_valid, req_op, req_a, req_b, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_p
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_p
  );
endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequencer in front of the shared combinational ALU. Accepts
//               one request at a time, drives the ALU for a single pass, or
//               iterates the ALU's 1-bit shift for multi-bit shifts, and
//               returns the result with N/Z/P condition codes.
// Ports       : clk, rst_n          - clock, async active-low reset
//               bus (slave)         - request/response channels
//               alu_in1/in2/op      - drive the ALU
//               alu_out/zero/neg    - ALU result and flags
//               busy                - high in any state other than IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_if.slave         bus,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy
);

  localparam logic [2:0] OP_LSHF = 3'd4;
  localparam logic [2:0] OP_RSHF = 3'd5;
  localparam logic [2:0] OP_ZERO = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q,    op_d;
  // a_q doubles as the shift accumulator: it is loaded with operand A on
  // accept and overwritten by the ALU output on every shift step.
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             n_q,     n_d;
  logic             z_q,     z_d;
  logic             p_q,     p_d;

  logic             req_ready_w;
  logic             is_shift_w;
  logic             pos_w;

  assign is_shift_w = (bus.req_op == OP_LSHF) || (bus.req_op == OP_RSHF);
  assign pos_w      = ~alu_neg & ~alu_zero;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    n_d         = n_q;
    z_d         = z_q;
    p_d         = p_q;
    req_ready_w = 1'b0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_op      = OP_ZERO;

    case (state_q)
      S_IDLE: begin
        req_ready_w = 1'b1;
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          cnt_d   = bus.req_amt;
          op_d    = bus.req_op;
          state_d = S_EXEC;
          if (is_shift_w) begin
            if (bus.req_amt != '0) begin
              state_d = S_SHIFT;
            end else begin
              // A zero-length shift is just operand A passed through.
              op_d = OP_PASS;
            end
          end
        end
      end

      S_EXEC: begin
        alu_in1 = a_q;
        alu_in2 = b_q;
        alu_op  = op_q;
        data_d  = alu_out;
        n_d     = alu_neg;
        z_d     = alu_zero;
        p_d     = pos_w;
        state_d = S_DONE;
      end

      S_SHIFT: begin
        alu_in1 = a_q;
        alu_in2 = b_q;
        alu_op  = op_q;
        a_d     = alu_out;
        cnt_d   = cnt_q - AMT_W'(1);
        // Last step: the ALU is producing the final shifted value now.
        if (cnt_q == AMT_W'(1)) begin
          data_d  = alu_out;
          n_d     = alu_neg;
          z_d     = alu_zero;
          p_d     = pos_w;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      n_q     <= n_d;
      z_q     <= z_d;
      p_q     <= p_d;
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_n     = n_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_p     = p_q;
  assign busy          = (state_q != S_IDLE);

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq. Provides a combinational
//               ALU model, drives requests over the interface and compares
//               responses with a reference model of the sequencer's result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_neg, busy;

  int checks = 0;
  int errors = 0;

  logic [2:0]  tr_op[$];
  logic [15:0] tr_in1[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16), .AMT_W(4)) bus ();

  alu_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .busy     (busy)
  );

  // Shared ALU environment model.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      3'd0: alu_out = alu_in1 + alu_in2;
      3'd1: alu_out = alu_in1 & alu_in2;
      3'd2: alu_out = ~alu_in1;
      3'd3: alu_out = alu_in1 ^ alu_in2;
      3'd4: alu_out = {alu_in1[14:0], 1'b0};
      3'd5: alu_out = {1'b0, alu_in1[15:1]};
      3'd6: alu_out = 16'h0000;
      default: alu_out = alu_in1;
    endcase
    alu_zero = (alu_out == 16'h0000);
    alu_neg  = alu_out[15];
  end

  // Record every cycle in which the sequencer actively drives the ALU.
  always @(negedge clk) begin
    if (rst_n && busy && alu_op != 3'd6) begin
      tr_op.push_back(alu_op);
      tr_in1.push_back(alu_in1);
    end
  end

  // Reference: whole-operation result, shifts done in one go.
  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] amt);
    logic [15:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a & b;
      3'd2: r = ~a;
      3'd3: r = a ^ b;
      3'd4: r = a << amt;
      3'd5: r = a >> amt;
      3'd6: r = 16'h0000;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [15:0] r);
    if (r[15])            return 3'b100;
    else if (r == 16'h0)  return 3'b010;
    else                  return 3'b001;
  endfunction

  // Cycles from the accept cycle (counted as 1) until rsp_valid is seen.
  function automatic int ref_latency(input logic [2:0] op, input logic [3:0] amt);
    if ((op == 3'd4 || op == 3'd5) && amt != 4'd0) return 1 + int'(amt);
    return 2;
  endfunction

  // Drive one request, return once rsp_valid is high (posedge + 1).
  task automatic send_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] amt, output int lat, output bit leak,
                          output bit tmo);
    int w;
    leak = 1'b0;
    tmo  = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_amt   = amt;
    w = 0;
    while (!bus.req_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    bus.req_amt   = 4'($urandom);
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin
      if (bus.req_ready) leak = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid) tmo = 1'b1;
  endtask

  task automatic consume(input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b expected 100",
               {bus.req_ready, bus.rsp_valid, busy});
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== 19'h0) begin
      errors++;
      $display("FAIL reset_rsp: data=%h nzp=%b expected 0000/000", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    checks++;
    if ({alu_in1, alu_in2, alu_op} !== {16'h0, 16'h0, 3'd6}) begin
      errors++;
      $display("FAIL reset_alu: in1=%h in2=%h op=%0d expected 0000/0000/6", alu_in1, alu_in2, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; bit leak, tmo;
    send_req(3'd0, 16'h1234, 16'h0001, 4'd0, lat, leak, tmo);
    checks++;
    if (tmo || lat != 2) begin
      errors++;
      $display("FAIL add_latency: got %0d (timeout=%0d) expected 2", lat, tmo);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h1235, 3'b001}) begin
      errors++;
      $display("FAIL add_result: data=%h nzp=%b expected 1235/001", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    checks++;
    if (leak || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ready_low: req_ready seen high while busy (leak=%0d now=%b) expected 0",
               leak, bus.req_ready);
    end
    consume(0);
    checks++;
    if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL add_consume: valid/ready/busy=%b expected 010",
               {bus.rsp_valid, bus.req_ready, busy});
    end
  endtask

  task automatic test_lshf();
    int lat; bit leak, tmo;
    logic [63:0] got_in1;
    bit ops_ok;
    tr_op.delete(); tr_in1.delete();
    send_req(3'd4, 16'h00F1, 16'h5555, 4'd4, lat, leak, tmo);
    checks++;
    if (tmo || lat != 5) begin
      errors++;
      $display("FAIL lshf_latency: got %0d (timeout=%0d) expected 5", lat, tmo);
    end
    got_in1 = '0;
    ops_ok  = 1'b1;
    foreach (tr_op[i]) begin
      if (tr_op[i] != 3'd4) ops_ok = 1'b0;
      if (i < 4) got_in1[63-16*i -: 16] = tr_in1[i];
    end
    checks++;
    if (tr_op.size() != 4 || !ops_ok) begin
      errors++;
      $display("FAIL lshf_op_cycles: %0d active cycles (all op4=%0d) expected 4 with op 4",
               tr_op.size(), ops_ok);
    end
    checks++;
    if (got_in1 !== 64'h00F1_01E2_03C4_0788) begin
      errors++;
      $display("FAIL lshf_in1_seq: got %h expected 00f101e203c40788", got_in1);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h0F10, 3'b001}) begin
      errors++;
      $display("FAIL lshf_result: data=%h nzp=%b expected 0f10/001", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
  endtask

  task automatic test_rshf();
    int lat; bit leak, tmo;
    tr_op.delete(); tr_in1.delete();
    send_req(3'd5, 16'h8000, 16'h0000, 4'd0, lat, leak, tmo);
    checks++;
    if (tmo || lat != 2 || tr_op.size() != 1 || tr_op[0] != 3'd7 || tr_in1[0] != 16'h8000) begin
      errors++;
      $display("FAIL rshf0_exec: lat=%0d active=%0d expected lat 2 with one op 7 cycle",
               lat, tr_op.size());
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h8000, 3'b100}) begin
      errors++;
      $display("FAIL rshf0_result: data=%h nzp=%b expected 8000/100", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(1);
    send_req(3'd5, 16'h8000, 16'h0000, 4'd15, lat, leak, tmo);
    checks++;
    if (tmo || lat != 16) begin
      errors++;
      $display("FAIL rshf15_latency: got %0d (timeout=%0d) expected 16", lat, tmo);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h0001, 3'b001}) begin
      errors++;
      $display("FAIL rshf15_result: data=%h nzp=%b expected 0001/001", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
  endtask

  task automatic test_logic();
    int lat; bit leak, tmo;
    send_req(3'd3, 16'hA5A5, 16'hA5A5, 4'd3, lat, leak, tmo);
    checks++;
    if (tmo || {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h0000, 3'b010}) begin
      errors++;
      $display("FAIL xor_zero: data=%h nzp=%b expected 0000/010", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
    send_req(3'd2, 16'h0000, 16'h1234, 4'd0, lat, leak, tmo);
    checks++;
    if (tmo || {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'hFFFF, 3'b100}) begin
      errors++;
      $display("FAIL not_neg: data=%h nzp=%b expected ffff/100", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
    send_req(3'd6, 16'hBEEF, 16'h1234, 4'd0, lat, leak, tmo);
    checks++;
    if (tmo || {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h0000, 3'b010}) begin
      errors++;
      $display("FAIL zero_op: data=%h nzp=%b expected 0000/010", bus.rsp_data,
               {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
  endtask

  task automatic test_backpressure();
    int lat; bit leak, tmo;
    logic [18:0] held;
    logic [15:0] a2, b2;
    int w;
    send_req(3'd1, 16'hF0F0, 16'h3C3C, 4'd0, lat, leak, tmo);
    held = {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p};
    checks++;
    if (tmo || held !== {16'h3030, 3'b001}) begin
      errors++;
      $display("FAIL bp_result: data/nzp=%h expected %h", held, {16'h3030, 3'b001});
    end
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_a     = a2;
    bus.req_b     = b2;
    bus.req_amt   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!bus.rsp_valid || bus.req_ready || {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b data/nzp=%h expected 1/0/%h", i,
                 bus.rsp_valid, bus.req_ready, {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p}, held);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({busy, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_no_accept_on_consume: busy/valid/ready=%b expected 001",
               {busy, bus.rsp_valid, bus.req_ready});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_next: busy=%b expected 1", busy);
    end
    w = 0;
    while (!bus.rsp_valid && w < 40) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (!bus.rsp_valid || bus.rsp_data !== (a2 ^ b2)) begin
      errors++;
      $display("FAIL bp_second_result: valid=%b data=%h expected 1/%h", bus.rsp_valid,
               bus.rsp_data, a2 ^ b2);
    end
    consume(0);
  endtask

  task automatic test_reset_mid();
    int lat; bit leak, tmo;
    bit saw;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_a     = 16'h1357;
    bus.req_b     = 16'h0000;
    bus.req_amt   = 4'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy, bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p,
         alu_in1, alu_in2, alu_op} !== {3'b100, 19'h0, 32'h0, 3'd6}) begin
      errors++;
      $display("FAIL midreset_outputs: ready=%b valid=%b busy=%b data=%h in1=%h op=%0d expected reset values",
               bus.req_ready, bus.rsp_valid, busy, bus.rsp_data, alu_in1, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL midreset_no_rsp: saw=%0d expected 0", saw);
    end
    send_req(3'd0, 16'h7FFF, 16'h0001, 4'd0, lat, leak, tmo);
    checks++;
    if (tmo || lat != 2 || {bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {16'h8000, 3'b100}) begin
      errors++;
      $display("FAIL midreset_add: lat=%0d data=%h nzp=%b expected 2/8000/100", lat,
               bus.rsp_data, {bus.rsp_n, bus.rsp_z, bus.rsp_p});
    end
    consume(0);
  endtask

  task automatic test_random();
    int lat; bit leak, tmo;
    logic [2:0]  op;
    logic [15:0] a, b, r;
    logic [3:0]  amt;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom);
      a   = 16'($urandom);
      b   = 16'($urandom);
      amt = 4'($urandom);
      if (i % 5 == 0) b = a;
      r = ref_result(op, a, b, amt);
      send_req(op, a, b, amt, lat, leak, tmo);
      checks++;
      if (tmo || lat != ref_latency(op, amt) || leak) begin
        errors++;
        $display("FAIL rand%0d_timing: op=%0d amt=%0d lat=%0d leak=%0d expected lat %0d", i,
                 op, amt, lat, leak, ref_latency(op, amt));
      end
      checks++;
      if ({bus.rsp_data, bus.rsp_n, bus.rsp_z, bus.rsp_p} !== {r, ref_nzp(r)}) begin
        errors++;
        $display("FAIL rand%0d_result: op=%0d a=%h b=%h amt=%0d got %h/%b expected %h/%b", i,
                 op, a, b, amt, bus.rsp_data, {bus.rsp_n, bus.rsp_z, bus.rsp_p}, r, ref_nzp(r));
      end
      consume($urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 16'h0;
    bus.req_b     = 16'h0;
    bus.req_amt   = 4'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_lshf();
    test_rshf();
    test_logic();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequencer in front of the shared 16-bit ALU (op codes 0 add, 1 and, 2 not, 3 xor, 4 lshf-by-1, 5 rshf-by-1, 6 zero, 7 pass in1). It accepts one operation request at a time over a valid/ready handshake and drives the ALU's in1, in2 and op inputs.
- Single-pass ops complete in one ALU cycle.
- Multi-bit shifts (LC-3b SHF amount) iterate the ALU's 1-bit shift, feeding back the result each cycle.
It returns the result with N/Z/P condition codes on a valid/ready response channel.

Parameters:
WIDTH, 16, datapath width; must equal the ALU width.
AMT_W, 4, shift-amount width; the maximum shift is 2^AMT_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_op  input  3  ALU op code, 0..7.
req_a  input  WIDTH  operand A, driven to ALU in1.
req_b  input  WIDTH  operand B, driven to ALU in2.
req_amt  input  AMT_W  shift amount; ignored for op not 4/5.
alu_in1  output  WIDTH  to ALU in1.
alu_in2  output  WIDTH  to ALU in2.
alu_op  output  3  to ALU op.
alu_out  input  WIDTH  ALU result (combinational from alu_in1/alu_in2/alu_op).
alu_zero  input  1  ALU zero flag.
alu_neg  input  1  ALU negative flag.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_data  output  WIDTH  result.
rsp_n, rsp_z, rsp_p  output  1 each  condition codes of rsp_data.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While rst_n=0:
  - state = IDLE; all registers cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_n/z/p=0, busy=0, alu_in1=0, alu_in2=0, alu_op=6.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - Outputs: req_ready=1, alu_op=6, alu_in1=0, alu_in2=0.
  - On req_valid&req_ready, latch op, a, b, amt. The next state is chosen as follows:
    - op in {4,5} and amt!=0 -> SHIFT; acc<=a, cnt<=amt.
    - op in {4,5} and amt==0 -> EXEC with the latched op replaced by 7 (pass), so the result is a.
    - otherwise -> EXEC.
- EXEC (exactly 1 cycle):
  - alu_in1=a_reg, alu_in2=b_reg, alu_op=op_reg.
  - On the edge: rsp_data<=alu_out, rsp_n<=alu_neg, rsp_z<=alu_zero, rsp_p<=~alu_neg&~alu_zero; then -> DONE.
- SHIFT:
  - alu_in1=acc, alu_in2=b_reg, alu_op=op_reg (4 or 5).
  - Each edge: acc<=alu_out, cnt<=cnt-1.
  - When cnt==1: capture rsp_data and flags as in EXEC, then -> DONE.
  - A shift by amt occupies exactly amt SHIFT cycles.
  - Shifts are logical: the ALU's rshf semantics apply per step, and bits shifted out are lost.
- DONE:
  - rsp_valid=1; rsp_data and flags held stable.
  - When rsp_ready=1, return to IDLE on that edge.
  - alu_op=6, alu_in1=0, alu_in2=0.
- Handshake:
  - req_ready=0 in EXEC, SHIFT and DONE. A new request is never accepted in the cycle the response is consumed; the earliest acceptance is the following IDLE cycle.
  - req_* inputs are don't-care outside the accept cycle.
- Latency, with the accept edge at T:
  - Single-pass ops, and shifts with amt==0: rsp_valid rises at T+2.
  - Shifts with amt=n: rsp_valid rises at T+1+n, so max 16 cycles for AMT_W=4.
- Flags: taken from the ALU on the final computing cycle. Exactly one of rsp_n/z/p is 1 whenever rsp_valid=1.
- Op 6 yields rsp_data=0, z=1. Op 7 yields rsp_data=a.
- Reset mid-operation (any state): immediate return to IDLE. An in-flight request or unconsumed response is discarded; no rsp_valid is produced for it.
- rsp_ready held high in DONE: single-cycle rsp_valid pulse.

Test Plan:
1. Reset release; add a=0x1234 b=0x0001 -> rsp_data=0x1235, p=1, rsp_valid exactly 2 cycles after accept; req_ready=0 until the response is consumed.
2. lshf a=0x00F1 amt=4 -> alu_op=4 for exactly 4 cycles with alu_in1 sequence 0x00F1, 0x01E2, 0x03C4, 0x0788; rsp_data=0x0F10, p=1, valid 5 cycles after accept.
3. rshf a=0x8000 amt=0 -> single EXEC cycle with alu_op=7; rsp_data=0x8000, n=1. Then rshf a=0x8000 amt=15 -> rsp_data=0x0001, p=1.
4. xor a=b=0xA5A5 -> rsp_data=0, z=1. Then not a=0x0000 -> 0xFFFF, n=1.
5. Backpressure: rsp_ready=0 for 3 cycles in DONE -> rsp_valid, rsp_data and flags stable; req_valid held high is not accepted until the cycle after rsp_ready=1.
6. Assert rst_n=0 during SHIFT of amt=10 after 3 steps -> outputs take reset values immediately. After release, no rsp_valid appears, and a new add request completes normally.
